// File: rtl/cacheline_adaptor.sv
// Cache-line <-> burst-memory adaptor.
// Splits one cache-line write into BEATS memory beats and assembles BEATS
// memory beats into one cache line for a refill. The cache side sees a
// single request held until a one-cycle resp_o completion pulse.
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,

    // Cache side
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,

    // Memory side
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;
    logic [LINE_WIDTH-1:0]   buf_q,   buf_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;

    // State, beat counter, line buffer and latched line address.
    // NOTE: non-blocking assignments here so every flop samples the values
    // computed in the previous cycle, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // NOTE: the line buffer is a wide register, not a RAM, and it must
            // read as zero right after reset, so it is reset like any flop.
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic: request capture, beat counting, line assembly.
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        addr_d  = addr_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (write_i || read_i) begin
                    addr_d = address_i & ~OFF_MASK;
                end
                // A writeback wins over a refill when both are requested.
                if (write_i) begin
                    buf_d   = line_i;
                    state_d = WRITE;
                end else if (read_i) begin
                    state_d = READ;
                end
            end

            READ: begin
                if (resp_i) begin
                    buf_d[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end

            WRITE: begin
                if (resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state, so reset clears them at once.
    always_comb begin
        line_o    = buf_q;
        burst_o   = '0;
        address_o = '0;
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
            end
            READ: begin
                read_o    = 1'b1;
                address_o = addr_q;
            end
            WRITE: begin
                write_o   = 1'b1;
                address_o = addr_q;
                burst_o   = buf_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH];
            end
            DONE: begin
                resp_o    = 1'b1;
                address_o = addr_q;
            end
            default: begin
            end
        endcase
    end

endmodule
